// File: rtl/bcd_convp_pkg.sv
// Shared constants and width derivations for the BCD converter.
// Everything here is elaboration-time only.
package bcd_convp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input logic [63:0] v);
    int r;
    logic [63:0] p;
    r = 0;
    p = 64'd1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Remainder must hold both the raw input and any scaled remainder below 10^digits.
  function automatic int work_w(input int bin_w, input int dec_digits);
    int d;
    d = clog2(pow10(dec_digits));
    return (bin_w > d) ? bin_w : d;
  endfunction

  function automatic int ndig_w(input int dec_digits);
    return clog2(64'(dec_digits + 1));
  endfunction

  function automatic logic [63:0] truss(input int dec_digits);
    return 64'd8 * pow10(dec_digits - 1);
  endfunction

endpackage

// File: rtl/bcd_lzb_blank.sv
// Replaces digits above the most significant non-zero digit with 4'hF when
// blanking is enabled; purely combinational.
module bcd_lzb_blank #(
  parameter int DEC_DIGITS = 8,
  parameter int NDIG_W     = 4
) (
  input  logic [4*DEC_DIGITS-1:0] raw,
  input  logic [NDIG_W-1:0]       ndig,
  input  logic                    en,
  output logic [4*DEC_DIGITS-1:0] dec
);

  always_comb begin
    dec = raw;
    // Digit 0 always shows, so a zero value reads as a single 0.
    for (int i = 1; i < DEC_DIGITS; i++) begin
      if (en && (i >= int'(ndig))) dec[4*i +: 4] = 4'hF;
    end
  end

endmodule

// File: rtl/bcd_convp.sv
// Binary to packed BCD by restoring subtraction, one weight per clock, MSD first.
// 4*DEC_DIGITS cycles per result (1 on overflow); result held until out_ready.
module bcd_convp
  import bcd_convp_pkg::*;
#(
  parameter int BIN_W      = 26,
  parameter int DEC_DIGITS = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIN_W-1:0]                  bin_in,
  input  logic                              lzb_en,
  input  logic                              clr,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [4*DEC_DIGITS-1:0]           dec_out,
  output logic [ndig_w(DEC_DIGITS)-1:0]     out_ndig,
  output logic                              out_ovf
);

  localparam int                WORK_W     = work_w(BIN_W, DEC_DIGITS);
  localparam int                NDIG_W     = ndig_w(DEC_DIGITS);
  localparam int                IDX_W      = (clog2(64'(DEC_DIGITS)) > 0) ? clog2(64'(DEC_DIGITS)) : 1;
  localparam logic [63:0]       LIMIT      = pow10(DEC_DIGITS);
  localparam int                LIMIT_BITS = clog2(LIMIT + 64'd1);
  localparam logic [WORK_W-1:0] TRUSS      = WORK_W'(truss(DEC_DIGITS));

  state_t                         state;
  logic [WORK_W-1:0]              rem;
  logic [WORK_W-1:0]              weight;
  logic [3:0]                     mask;
  logic [IDX_W-1:0]               idx;
  logic [DEC_DIGITS-1:0][3:0]     dig;
  logic [NDIG_W-1:0]              ndig;
  logic                           ovf;
  logic                           lzb;

  logic                           ovf_hit;
  logic                           take;
  logic [WORK_W-1:0]              rem_sub;
  logic [3:0]                     dig_new;
  logic [NDIG_W-1:0]              idx_p1;

  // Narrow inputs can never reach 10^DEC_DIGITS, so skip the compare entirely.
  if (BIN_W >= LIMIT_BITS) begin : g_ovf
    assign ovf_hit = (64'(bin_in) >= LIMIT);
  end else begin : g_no_ovf
    assign ovf_hit = 1'b0;
  end

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign take     = (rem >= weight);
  assign rem_sub  = take ? (rem - weight) : rem;
  assign dig_new  = dig[idx] | (take ? mask : 4'b0000);
  assign idx_p1   = NDIG_W'(idx) + NDIG_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      rem       <= '0;
      weight    <= '0;
      mask      <= 4'b0000;
      idx       <= '0;
      dig       <= '0;
      ndig      <= NDIG_W'(1);
      ovf       <= 1'b0;
      lzb       <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      rem       <= '0;
      weight    <= '0;
      mask      <= 4'b0000;
      idx       <= '0;
      dig       <= '0;
      ndig      <= NDIG_W'(1);
      ovf       <= 1'b0;
      lzb       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (in_valid && in_ready) begin
            lzb    <= lzb_en;
            weight <= TRUSS;
            mask   <= 4'b1000;
            idx    <= IDX_W'(DEC_DIGITS - 1);
            if (ovf_hit) begin
              ovf       <= 1'b1;
              rem       <= '0;
              dig       <= {DEC_DIGITS{4'h9}};
              ndig      <= NDIG_W'(DEC_DIGITS);
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              ovf       <= 1'b0;
              rem       <= WORK_W'(bin_in);
              dig       <= '0;
              ndig      <= NDIG_W'(1);
              state     <= CONV;
              out_valid <= 1'b0;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        CONV: begin
          dig[idx] <= dig_new;
          if (mask == 4'b0001) begin
            // Scale the leftover by ten so the same weight ladder serves every digit.
            rem    <= (rem_sub << 3) + (rem_sub << 1);
            weight <= TRUSS;
            mask   <= 4'b1000;
            if ((dig_new != 4'd0) && (idx_p1 > ndig)) ndig <= idx_p1;
            if (idx == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              idx <= idx - IDX_W'(1);
            end
          end else begin
            rem    <= rem_sub;
            weight <= weight >> 1;
            mask   <= mask >> 1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_ndig = ndig;
  assign out_ovf  = ovf;

  bcd_lzb_blank #(
    .DEC_DIGITS (DEC_DIGITS),
    .NDIG_W     (NDIG_W)
  ) u_blank (
    .raw  (dig),
    .ndig (ndig),
    .en   (lzb),
    .dec  (dec_out)
  );

endmodule
